board_win_checker: RTL

Read-side companion to the board cell storage: after a move is written, this block walks the stored board through a read port and decides whether the newly placed stone completes five in a row. It sits between the game-control FSM, which issues `start` with the move, and the board register array, which it reads one cell per cycle. It never writes the board.

---
 rtl/board_win_checker.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/board_win_checker.sv
// Five-in-a-row detector for the stone just placed: walks the board read port
// one cell per cycle along four directions and reports win/no-win.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start
// SCAN_POS | stepping +dx,+dy from the move in the current direction
// SCAN_NEG | stepping -dx,-dy from the move in the current direction
// DONE     | one-cycle result strobe, then IDLE
module board_win_checker #(
  parameter int N  = 15,
  parameter int CW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] mv_x,
  input  logic [CW-1:0] mv_y,
  input  logic [1:0]    player,
  output logic          rd_en,
  output logic [CW-1:0] rd_x,
  output logic [CW-1:0] rd_y,
  input  logic [1:0]    rd_data,
  output logic          busy,
  output logic          done,
  output logic          win
);

  typedef enum logic [1:0] {IDLE, SCAN_POS, SCAN_NEG, DONE} state_t;

  localparam logic [CW:0] LIM  = (CW+1)'(N);
  localparam logic [CW:0] ONE  = (CW+1)'(1);
  localparam logic [CW:0] MONE = '1;

  state_t      state;
  logic [CW:0] cur_x, cur_y;
  logic [CW:0] org_x, org_y;
  logic [1:0]  dir;
  logic [1:0]  ply;
  logic [2:0]  cnt;
  logic        scanning;
  logic        in_bounds;
  logic        match;
  logic [1:0]  dir_nxt;

  // Cursors are CW+1 bits wide and treated as two's complement, so a step
  // below zero shows up as the top bit set.
  function automatic logic [CW:0] step_x(input logic [1:0] d);
    return (d == 2'd1) ? '0 : ONE;
  endfunction

  function automatic logic [CW:0] step_y(input logic [1:0] d);
    case (d)
      2'd0:    return '0;
      2'd3:    return MONE;
      default: return ONE;
    endcase
  endfunction

  assign scanning  = (state == SCAN_POS) || (state == SCAN_NEG);
  assign in_bounds = scanning && !cur_x[CW] && (cur_x < LIM) &&
                     !cur_y[CW] && (cur_y < LIM);
  assign match     = in_bounds && (rd_data == ply);
  assign dir_nxt   = dir + 2'd1;

  assign rd_en = in_bounds;
  assign rd_x  = cur_x[CW-1:0];
  assign rd_y  = cur_y[CW-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cur_x <= '0;
      cur_y <= '0;
      org_x <= '0;
      org_y <= '0;
      dir   <= '0;
      ply   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      win   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            win   <= 1'b0;
            busy  <= 1'b1;
            org_x <= {1'b0, mv_x};
            org_y <= {1'b0, mv_y};
            ply   <= player;
            dir   <= 2'd0;
            cnt   <= 3'd1;
            if (player == 2'b01 || player == 2'b10) begin
              state <= SCAN_POS;
              cur_x <= {1'b0, mv_x} + ONE;
              cur_y <= {1'b0, mv_y};
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        SCAN_POS, SCAN_NEG: begin
          if (match) begin
            if (cnt == 3'd4) begin
              cnt   <= 3'd5;
              win   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cnt <= cnt + 3'd1;
              if (state == SCAN_POS) begin
                cur_x <= cur_x + step_x(dir);
                cur_y <= cur_y + step_y(dir);
              end else begin
                cur_x <= cur_x - step_x(dir);
                cur_y <= cur_y - step_y(dir);
              end
            end
          end else if (state == SCAN_POS) begin
            state <= SCAN_NEG;
            cur_x <= org_x - step_x(dir);
            cur_y <= org_y - step_y(dir);
          end else if (dir == 2'd3) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            dir   <= dir_nxt;
            cnt   <= 3'd1;
            state <= SCAN_POS;
            cur_x <= org_x + step_x(dir_nxt);
            cur_y <= org_y + step_y(dir_nxt);
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
